// File: rtl/vector_add_writeback_if.sv
// Handshake bundle between the vector add unit, the writeback collector and the VRF write port.
// master drives result beats and VRF ready; slave is the collector.
interface vector_add_writeback_if #(
  parameter int SLICE_ADDR_WIDTH = 8
);
  logic                        in_valid;
  logic                        in_ready;
  logic [63:0]                 in_vd;
  logic [63:0]                 in_vd_high;
  logic [1:0]                  in_bit_mode;
  logic                        in_mask_mode;
  logic                        in_widening_mode;
  logic [SLICE_ADDR_WIDTH-1:0] in_base_addr;
  logic                        in_last;
  logic                        wb_valid;
  logic                        wb_ready;
  logic [SLICE_ADDR_WIDTH-1:0] wb_addr;
  logic [63:0]                 wb_data;
  logic [7:0]                  wb_byte_enable;
  logic                        wb_last;
  logic                        done;
  logic [31:0]                 perf_write_count;
  logic [31:0]                 perf_stall_count;

  modport master (
    output in_valid, in_vd, in_vd_high, in_bit_mode, in_mask_mode, in_widening_mode,
           in_base_addr, in_last, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data, wb_byte_enable, wb_last, done,
           perf_write_count, perf_stall_count
  );

  modport slave (
    input  in_valid, in_vd, in_vd_high, in_bit_mode, in_mask_mode, in_widening_mode,
           in_base_addr, in_last, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data, wb_byte_enable, wb_last, done,
           perf_write_count, perf_stall_count
  );
endinterface

// File: rtl/vector_add_writeback.sv
// Turns vector add result beats into VRF slice writes (plain, widened, packed mask); one-cycle latency,
// in_ready drops while the output register is stalled or the widened high word is pending.
// Optional perf counters: DRAGONFANG_WB_PERF_COUNTERS_EN.
module vector_add_writeback #(
  parameter int SLICE_ADDR_WIDTH = 8
) (
  input logic                   clock,
  input logic                   reset,
  vector_add_writeback_if.slave bus
);
  localparam logic [1:0] ENABLED_8BIT_MODE  = 2'd0;
  localparam logic [1:0] ENABLED_16BIT_MODE = 2'd1;
  localparam logic [1:0] ENABLED_32BIT_MODE = 2'd2;
  localparam logic [1:0] ENABLED_64BIT_MODE = 2'd3;

  typedef logic [SLICE_ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, RUN, HIGH} state_t;

  state_t      state_q, state_d;
  logic        wb_valid_q, wb_valid_d;
  addr_t       wb_addr_q, wb_addr_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic [7:0]  wb_be_q, wb_be_d;
  logic        wb_last_q, wb_last_d;
  logic [1:0]  bit_mode_q, bit_mode_d;
  logic        mask_q, mask_d, widen_q, widen_d;
  addr_t       base_q, base_d, idx_q, idx_d;
  logic [63:0] acc_q, acc_d, high_q, high_d;
  logic [6:0]  fill_q, fill_d;
  logic        high_last_q, high_last_d;

  logic        accept, wb_fire, first;
  logic [1:0]  bm_e;
  logic        mask_e, widen_e;
  addr_t       base_e, idx_e;
  logic [63:0] acc_e, bits, acc_new;
  logic [6:0]  fill_e, fill_new, ebits;
  logic [7:0]  be_new;

  assign bus.in_ready = !reset && (state_q != HIGH) && (!wb_valid_q || bus.wb_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign wb_fire      = wb_valid_q && bus.wb_ready;

  always_comb begin
    state_d     = state_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_be_d     = wb_be_q;
    wb_last_d   = wb_last_q;
    bit_mode_d  = bit_mode_q;
    mask_d      = mask_q;
    widen_d     = widen_q;
    base_d      = base_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    high_d      = high_q;
    high_last_d = high_last_q;

    // The first beat of an instruction supplies mode and base; later beats use the latched copies.
    first   = (state_q == IDLE);
    bm_e    = first ? bus.in_bit_mode      : bit_mode_q;
    mask_e  = first ? bus.in_mask_mode     : mask_q;
    widen_e = first ? bus.in_widening_mode : widen_q;
    base_e  = first ? bus.in_base_addr     : base_q;
    idx_e   = first ? '0 : idx_q;
    acc_e   = first ? '0 : acc_q;
    fill_e  = first ? '0 : fill_q;

    unique case (bm_e)
      ENABLED_8BIT_MODE:  begin ebits = 7'd8; bits = {56'b0, bus.in_vd[7:0]}; end
      ENABLED_16BIT_MODE: begin ebits = 7'd4; bits = {60'b0, bus.in_vd[3:0]}; end
      ENABLED_32BIT_MODE: begin ebits = 7'd2; bits = {62'b0, bus.in_vd[1:0]}; end
      default:            begin ebits = 7'd1; bits = {63'b0, bus.in_vd[0]};   end
    endcase
    acc_new  = acc_e | (bits << fill_e);
    fill_new = fill_e + ebits;
    be_new   = '0;
    for (int i = 0; i < 8; i++) be_new[i] = (fill_new > 7'(8 * i));

    if (wb_fire) wb_valid_d = 1'b0;

    unique case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          bit_mode_d = bm_e;
          mask_d     = mask_e;
          widen_d    = widen_e;
          base_d     = base_e;
          idx_d      = idx_e;
          acc_d      = acc_e;
          fill_d     = fill_e;
          state_d    = bus.in_last ? IDLE : RUN;
          if (widen_e) begin
            wb_valid_d  = 1'b1;
            wb_addr_d   = base_e + idx_e;
            wb_data_d   = bus.in_vd;
            wb_be_d     = 8'hFF;
            wb_last_d   = 1'b0;
            high_d      = bus.in_vd_high;
            high_last_d = bus.in_last;
            state_d     = HIGH;
          end else if (mask_e) begin
            // Flush only on a full word or the final beat; otherwise just accumulate.
            if (fill_new == 7'd64 || bus.in_last) begin
              wb_valid_d = 1'b1;
              wb_addr_d  = base_e + idx_e;
              wb_data_d  = acc_new;
              wb_be_d    = be_new;
              wb_last_d  = bus.in_last;
              idx_d      = idx_e + addr_t'(1);
              acc_d      = '0;
              fill_d     = '0;
            end else begin
              acc_d  = acc_new;
              fill_d = fill_new;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_addr_d  = base_e + idx_e;
            wb_data_d  = bus.in_vd;
            wb_be_d    = 8'hFF;
            wb_last_d  = bus.in_last;
            idx_d      = idx_e + addr_t'(1);
          end
        end
      end
      HIGH: begin
        if (wb_fire) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = base_q + idx_q + addr_t'(1);
          wb_data_d  = high_q;
          wb_be_d    = 8'hFF;
          wb_last_d  = high_last_q;
          idx_d      = idx_q + addr_t'(2);
          state_d    = high_last_q ? IDLE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_be_q     <= '0;
      wb_last_q   <= 1'b0;
      bit_mode_q  <= '0;
      mask_q      <= 1'b0;
      widen_q     <= 1'b0;
      base_q      <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      fill_q      <= '0;
      high_q      <= '0;
      high_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_be_q     <= wb_be_d;
      wb_last_q   <= wb_last_d;
      bit_mode_q  <= bit_mode_d;
      mask_q      <= mask_d;
      widen_q     <= widen_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      high_q      <= high_d;
      high_last_q <= high_last_d;
    end
  end

  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_addr        = wb_addr_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.wb_byte_enable = wb_be_q;
  assign bus.wb_last        = wb_last_q;
  assign bus.done           = wb_fire && wb_last_q;

`ifdef DRAGONFANG_WB_PERF_COUNTERS_EN
  logic [31:0] write_cnt_q, stall_cnt_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      write_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (wb_fire) write_cnt_q <= write_cnt_q + 32'd1;
      if (wb_valid_q && !bus.wb_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign bus.perf_write_count = write_cnt_q;
  assign bus.perf_stall_count = stall_cnt_q;
`else
  assign bus.perf_write_count = '0;
  assign bus.perf_stall_count = '0;
`endif
endmodule

// File: tb/tb_vector_add_writeback.sv
// Bench for vector_add_writeback: directed scenarios plus random instructions checked against
// an expected-write list built from the instruction's beats.
module tb_vector_add_writeback;
  typedef struct packed {
    logic [7:0]  addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        last;
  } wr_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vector_add_writeback_if #(.SLICE_ADDR_WIDTH(8)) bus ();
  vector_add_writeback #(.SLICE_ADDR_WIDTH(8)) dut (.clock(clock), .reset(reset), .bus(bus));

  wr_t         obs[$];
  wr_t         exp_q[$];
  logic [63:0] bvd[$];
  logic [63:0] bvdh[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic        rand_rdy = 1'b0;

  always @(negedge clock) begin
    if (!reset && bus.wb_valid && bus.wb_ready)
      obs.push_back({bus.wb_addr, bus.wb_data, bus.wb_byte_enable, bus.wb_last});
    if (!reset && bus.done) done_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_rdy) bus.wb_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input logic [63:0] vd, input logic [63:0] vdh, input logic [1:0] bm,
                           input logic mk, input logic wd, input logic [7:0] base, input logic last);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_vd = vd; bus.in_vd_high = vdh; bus.in_bit_mode = bm;
    bus.in_mask_mode = mk; bus.in_widening_mode = wd; bus.in_base_addr = base; bus.in_last = last;
    @(negedge clock);
    while (!bus.in_ready && n < 300) begin step(); @(negedge clock); n++; end
    total++;
    if (!bus.in_ready) begin bad++; $display("FAIL beat_accept timeout in_ready=%b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clock);
    while (bus.wb_valid && n < 400) begin step(); @(negedge clock); n++; end
    total++;
    if (bus.wb_valid) begin bad++; $display("FAIL drain timeout wb_valid=%b want 0", bus.wb_valid); end
    step();
  endtask

  // Expected writes: plain = one per beat, widened = low/high pairs, mask = bitstream cut into 64-bit words.
  task automatic model(input logic [1:0] bm, input logic mk, input logic wd, input logic [7:0] base);
    int n = bvd.size();
    wr_t w;
    exp_q.delete();
    if (wd) begin
      for (int i = 0; i < n; i++) begin
        w.addr = base + 8'(2 * i);     w.data = bvd[i];  w.be = 8'hFF; w.last = 1'b0;     exp_q.push_back(w);
        w.addr = base + 8'(2 * i + 1); w.data = bvdh[i]; w.be = 8'hFF; w.last = (i == n - 1); exp_q.push_back(w);
      end
    end else if (mk) begin
      logic bits[$];
      logic [63:0] t;
      int e = 8 >> bm;
      int nb, words, cnt;
      for (int i = 0; i < n; i++) begin
        t = bvd[i];
        for (int j = 0; j < e; j++) bits.push_back(t[j]);
      end
      nb = bits.size();
      words = (nb + 63) / 64;
      for (int k = 0; k < words; k++) begin
        cnt = nb - 64 * k;
        if (cnt > 64) cnt = 64;
        t = '0;
        for (int j = 0; j < cnt; j++) t[j] = bits[64 * k + j];
        w.addr = base + 8'(k); w.data = t; w.be = 8'((1 << ((cnt + 7) / 8)) - 1); w.last = (k == words - 1);
        exp_q.push_back(w);
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        w.addr = base + 8'(i); w.data = bvd[i]; w.be = 8'hFF; w.last = (i == n - 1);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic run_instr(input logic [1:0] bm, input logic mk, input logic wd, input logic [7:0] base);
    model(bm, mk, wd, base);
    for (int i = 0; i < bvd.size(); i++) send_beat(bvd[i], bvdh[i], bm, mk, wd, base, i == bvd.size() - 1);
    drain();
  endtask

  task automatic fill_beats(input int n);
    bvd.delete(); bvdh.delete();
    for (int i = 0; i < n; i++) begin
      bvd.push_back({$urandom, $urandom});
      bvdh.push_back({$urandom, $urandom});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_vd = '0; bus.in_vd_high = '0; bus.in_bit_mode = '0;
    bus.in_mask_mode = 1'b0; bus.in_widening_mode = 1'b0; bus.in_base_addr = '0; bus.in_last = 1'b0;
    bus.wb_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got %b want 0", bus.wb_valid); end
    total++; if ({bus.wb_addr, bus.wb_data, bus.wb_byte_enable, bus.wb_last} !== '0) begin
      bad++; $display("FAIL rst_wb_fields got a=%h d=%h be=%h l=%b want all 0", bus.wb_addr, bus.wb_data, bus.wb_byte_enable, bus.wb_last); end
    total++; if ({bus.done, bus.perf_write_count, bus.perf_stall_count} !== '0) begin
      bad++; $display("FAIL rst_done_perf got %b %0d %0d want 0", bus.done, bus.perf_write_count, bus.perf_stall_count); end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got %b want 1", bus.in_ready); end
    step();
  endtask

  task automatic test_normal();
    int s = obs.size();
    int d0 = done_cnt;
    fill_beats(3);
    model(2'd3, 1'b0, 1'b0, 8'h10);
    send_beat(bvd[0], bvdh[0], 2'd3, 1'b0, 1'b0, 8'h10, 1'b0);
    total++; if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 8'h10) begin
      bad++; $display("FAIL normal_latency got v=%b a=%h want v=1 a=10", bus.wb_valid, bus.wb_addr); end
    send_beat(bvd[1], bvdh[1], 2'd3, 1'b0, 1'b0, 8'h10, 1'b0);
    send_beat(bvd[2], bvdh[2], 2'd3, 1'b0, 1'b0, 8'h10, 1'b1);
    drain();
    total++; if (obs.size() - s !== exp_q.size()) begin bad++; $display("FAIL normal_count got %0d want %0d", obs.size() - s, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && s + i < obs.size(); i++) begin
      total++; if (obs[s + i] !== exp_q[i]) begin bad++; $display("FAIL normal_write%0d got %h want %h", i, obs[s + i], exp_q[i]); end
    end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL normal_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_widening();
    int s = obs.size();
    fill_beats(2);
    model(2'd0, 1'b0, 1'b1, 8'h20);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_vd = bvd[i]; bus.in_vd_high = bvdh[i]; bus.in_bit_mode = 2'd0;
      bus.in_mask_mode = 1'b0; bus.in_widening_mode = 1'b1; bus.in_base_addr = 8'h20; bus.in_last = (i == 1);
      @(negedge clock);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL widen_accept%0d got %b want 1", i, bus.in_ready); end
      step();
      bus.in_valid = 1'b0;
      @(negedge clock);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL widen_high_in_ready%0d got %b want 0", i, bus.in_ready); end
      step();
    end
    drain();
    total++; if (obs.size() - s !== exp_q.size()) begin bad++; $display("FAIL widen_count got %0d want %0d", obs.size() - s, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && s + i < obs.size(); i++) begin
      total++; if (obs[s + i] !== exp_q[i]) begin bad++; $display("FAIL widen_write%0d got %h want %h", i, obs[s + i], exp_q[i]); end
    end
  endtask

  task automatic test_mask();
    int s = obs.size();
    wr_t w16;
    bvd.delete(); bvdh.delete();
    for (int i = 0; i < 5; i++) begin
      bvd.push_back(({$urandom, $urandom} & ~64'hF) | 64'hA);
      bvdh.push_back({$urandom, $urandom});
    end
    run_instr(2'd1, 1'b1, 1'b0, 8'h30);
    w16 = {8'h30, 64'h00000000000AAAAA, 8'h07, 1'b1};
    total++; if (obs.size() - s !== 1) begin bad++; $display("FAIL mask16_count got %0d want 1", obs.size() - s); end
    total++; if (obs.size() > s && obs[s] !== w16) begin bad++; $display("FAIL mask16_write got %h want %h", obs[s], w16); end
    s = obs.size();
    bvd.delete(); bvdh.delete();
    for (int i = 0; i < 9; i++) begin
      bvd.push_back({$urandom, 24'($urandom), 8'(i)});
      bvdh.push_back('0);
    end
    run_instr(2'd0, 1'b1, 1'b0, 8'h50);
    total++; if (obs.size() - s !== 2) begin bad++; $display("FAIL mask8_count got %0d want 2", obs.size() - s); end
    for (int i = 0; i < exp_q.size() && s + i < obs.size(); i++) begin
      total++; if (obs[s + i] !== exp_q[i]) begin bad++; $display("FAIL mask8_write%0d got %h want %h", i, obs[s + i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    int s = obs.size();
    logic [31:0] p0, want;
    logic [80:0] snap;
    fill_beats(2);
    model(2'd2, 1'b0, 1'b0, 8'h60);
    bus.wb_ready = 1'b0;
    send_beat(bvd[0], bvdh[0], 2'd2, 1'b0, 1'b0, 8'h60, 1'b0);
    @(negedge clock);
    snap = {bus.wb_addr, bus.wb_data, bus.wb_byte_enable, bus.wb_last};
    p0 = bus.perf_stall_count;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      total++; if ({bus.wb_addr, bus.wb_data, bus.wb_byte_enable, bus.wb_last} !== snap || bus.wb_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold%0d got v=%b a=%h d=%h want held a=%h", c, bus.wb_valid, bus.wb_addr, bus.wb_data, snap[80:73]); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready%0d got %b want 0", c, bus.in_ready); end
    end
    @(posedge clock); #1 bus.wb_ready = 1'b1;
    @(negedge clock);
`ifdef DRAGONFANG_WB_PERF_COUNTERS_EN
    want = p0 + 32'd3;
`else
    want = 32'd0;
`endif
    total++; if (bus.perf_stall_count !== want) begin bad++; $display("FAIL stall_perf got %0d want %0d", bus.perf_stall_count, want); end
    step();
    send_beat(bvd[1], bvdh[1], 2'd2, 1'b0, 1'b0, 8'h60, 1'b1);
    drain();
    total++; if (obs.size() - s !== exp_q.size()) begin bad++; $display("FAIL stall_count got %0d want %0d", obs.size() - s, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && s + i < obs.size(); i++) begin
      total++; if (obs[s + i] !== exp_q[i]) begin bad++; $display("FAIL stall_write%0d got %h want %h", i, obs[s + i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    bus.wb_ready = 1'b0;
    send_beat({$urandom, $urandom}, {$urandom, $urandom}, 2'd0, 1'b0, 1'b1, 8'h30, 1'b0);
    @(negedge clock);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rmid_high_in_ready got %b want 0", bus.in_ready); end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL rmid_wb_valid got %b want 0", bus.wb_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got %b want 1", bus.in_ready); end
    step();
    bus.wb_ready = 1'b1;
    s = obs.size();
    fill_beats(2);
    run_instr(2'd3, 1'b0, 1'b0, 8'h40);
    total++; if (obs.size() - s !== exp_q.size()) begin bad++; $display("FAIL rmid_count got %0d want %0d", obs.size() - s, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && s + i < obs.size(); i++) begin
      total++; if (obs[s + i] !== exp_q[i]) begin bad++; $display("FAIL rmid_write%0d got %h want %h", i, obs[s + i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int s, kind, d0, s0;
    logic [31:0] w0, want;
    logic [7:0] base;
    logic [1:0] bm;
    rand_rdy = 1'b1;
    d0 = done_cnt;
    s0 = obs.size();
    w0 = bus.perf_write_count;
    for (int k = 0; k < 14; k++) begin
      kind = $urandom_range(0, 2);
      bm = 2'($urandom_range(0, 3));
      base = (k % 4 == 0) ? 8'hFE : 8'($urandom);
      fill_beats(kind == 2 ? $urandom_range(1, 20) : $urandom_range(1, 6));
      s = obs.size();
      run_instr(bm, kind == 2, kind == 1, base);
      total++; if (obs.size() - s !== exp_q.size()) begin bad++; $display("FAIL rand%0d_count got %0d want %0d", k, obs.size() - s, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && s + i < obs.size(); i++) begin
        total++; if (obs[s + i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_write%0d got %h want %h", k, i, obs[s + i], exp_q[i]); end
      end
    end
    total++; if (done_cnt - d0 !== 14) begin bad++; $display("FAIL rand_done got %0d want 14", done_cnt - d0); end
`ifdef DRAGONFANG_WB_PERF_COUNTERS_EN
    want = w0 + 32'(obs.size() - s0);
`else
    want = 32'd0;
`endif
    total++; if (bus.perf_write_count !== want) begin bad++; $display("FAIL rand_perf_write got %0d want %0d", bus.perf_write_count, want); end
    rand_rdy = 1'b0;
    bus.wb_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_widening();
    test_mask();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
